// File: rtl/mem_pkg.sv
// Shared encodings for the MFA/MOC memory responder.
// Size codes, read/write codes, FSM states and the captured request bundle.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic        rw;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] din;
    } req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: read extension, write byte enables, alignment check.
// Byte lanes are ordered by offset from the access address, lane 0 = Mem[A].
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  ofs,
    input  logic [31:0] rbytes,
    input  logic [31:0] din,
    output logic [31:0] rdata,
    output logic        err,
    output logic [3:0]  we,
    output logic [31:0] wbytes
);

    logic [31:0] rext;
    logic [3:0]  wmask;

    always_comb begin
        rext   = '0;
        err    = 1'b0;
        wmask  = 4'b0000;
        wbytes = '0;
        unique case (1'b1)
            size == SZ_BYTE: begin
                rext   = {{24{sgn & rbytes[31]}}, rbytes[31:24]};
                wmask  = 4'b0001;
                wbytes = {din[7:0], 24'h0};
            end
            size == SZ_HALF: begin
                err    = ofs[0];
                rext   = {{16{sgn & rbytes[31]}}, rbytes[31:16]};
                wmask  = 4'b0011;
                wbytes = {din[15:0], 16'h0};
            end
            size == SZ_WORD: begin
                err    = (ofs != 2'b00);
                rext   = rbytes;
                wmask  = 4'b1111;
                wbytes = din;
            end
            default: err = 1'b1;
        endcase
    end

    assign rdata = err ? 32'h0 : rext;
    assign we    = err ? 4'b0000 : wmask;

endmodule

// File: rtl/mem_moc_responder.sv
// Byte-addressed big-endian RAM answering MFA/MOC requests after LATENCY cycles.
// Array contents are not touched by reset; only the handshake state is.
module mem_moc_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int AW      = 9,
    parameter int LATENCY = 2
) (
    input  logic          Clk,
    input  logic          Clear,
    input  logic          MFA,
    input  logic          RW,
    input  logic [1:0]    Size,
    input  logic          Signed,
    input  logic [AW-1:0] Address,
    input  logic [31:0]   DataIn,
    output logic [31:0]   DataOut,
    output logic          MOC,
    output logic          Err
);

    localparam int LW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [7:0] Mem [0:DEPTH-1];

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    req_t          req, req_n;
    logic [LW-1:0] addr, addr_n;
    logic [31:0]   dout_n;
    logic          err_n;
    logic          access;
    logic          wen;

    logic [31:0] rbytes;
    logic [31:0] rdata;
    logic        aerr;
    logic [3:0]  we;
    logic [31:0] wbytes;
    logic        unused_addr;

    // Upper address bits alias onto the array
    assign unused_addr = ^Address;

    assign rbytes = {Mem[addr], Mem[addr + LW'(1)],
                     Mem[addr + LW'(2)], Mem[addr + LW'(3)]};

    mem_lane_align u_align (
        .size   (req.size),
        .sgn    (req.sgn),
        .ofs    (addr[1:0]),
        .rbytes (rbytes),
        .din    (req.din),
        .rdata  (rdata),
        .err    (aerr),
        .we     (we),
        .wbytes (wbytes)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        req_n   = req;
        addr_n  = addr;
        dout_n  = DataOut;
        err_n   = Err;
        access  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (MFA) begin
                    state_n    = ST_BUSY;
                    cnt_n      = CW'(LATENCY - 1);
                    req_n.rw   = RW;
                    req_n.size = Size;
                    req_n.sgn  = Signed;
                    req_n.din  = DataIn;
                    addr_n     = Address[LW-1:0];
                end
            end
            ST_BUSY: begin
                if (cnt == '0) begin
                    state_n = ST_DONE;
                    access  = 1'b1;
                    err_n   = aerr;
                    if (aerr)
                        dout_n = 32'h0;
                    else if (req.rw == RW_READ)
                        dout_n = rdata;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_DONE: begin
                if (!MFA) begin
                    state_n = ST_IDLE;
                    err_n   = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            req     <= '0;
            addr    <= '0;
            DataOut <= '0;
            Err     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            req     <= req_n;
            addr    <= addr_n;
            DataOut <= dout_n;
            Err     <= err_n;
        end
    end

    assign MOC = (state == ST_DONE);
    assign wen = access && (req.rw == RW_WRITE);

    always_ff @(posedge Clk) begin
        if (wen) begin
            for (int k = 0; k < 4; k++) begin
                if (we[k])
                    Mem[addr + LW'(k)] <= wbytes[31-8*k -: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_moc_responder.sv
// Scoreboard bench for mem_moc_responder: directed requests, monitor on MOC rise.
// A LATENCY=1 copy shares the request bus to check single-cycle timing.
module tb_mem_moc_responder;
    import mem_pkg::*;

    localparam int DEPTH = 256;
    localparam int AW    = 9;

    logic          Clk     = 1'b0;
    logic          Clear   = 1'b0;
    logic          MFA     = 1'b0;
    logic          RW      = 1'b0;
    logic [1:0]    Size    = 2'b00;
    logic          Signed  = 1'b0;
    logic [AW-1:0] Address = '0;
    logic [31:0]   DataIn  = '0;
    logic [31:0]   DataOut, DataOut1;
    logic          MOC, Err, MOC1, Err1;

    always #5 Clk = ~Clk;

    mem_moc_responder #(.DEPTH(DEPTH), .AW(AW), .LATENCY(2)) dut (
        .Clk(Clk), .Clear(Clear), .MFA(MFA), .RW(RW), .Size(Size),
        .Signed(Signed), .Address(Address), .DataIn(DataIn),
        .DataOut(DataOut), .MOC(MOC), .Err(Err)
    );

    mem_moc_responder #(.DEPTH(DEPTH), .AW(AW), .LATENCY(1)) dut1 (
        .Clk(Clk), .Clear(Clear), .MFA(MFA), .RW(RW), .Size(Size),
        .Signed(Signed), .Address(Address), .DataIn(DataIn),
        .DataOut(DataOut1), .MOC(MOC1), .Err(Err1)
    );

    typedef struct {
        logic [31:0] d;
        logic        e;
        logic        chkd;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    logic moc_q    = 1'b0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge Clk) begin : monitor
        exp_t x;
        if (MOC && !moc_q) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_moc", 32'd1, 32'd0);
            end else begin
                x = sbq.pop_front();
                check({x.nm, "_err"}, {31'h0, Err}, {31'h0, x.e});
                if (x.chkd)
                    check({x.nm, "_dout"}, DataOut, x.d);
            end
        end
        moc_q = MOC;
    end

    task automatic push(input logic rw, input logic [31:0] ed,
                        input logic ee, input string nm);
        exp_t x;
        x.d    = ed;
        x.e    = ee;
        x.chkd = (rw == RW_READ) || ee;
        x.nm   = nm;
        sbq.push_back(x);
    endtask

    task automatic do_req(input logic rw, input logic [1:0] sz,
                          input logic sg, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [31:0] ed,
                          input logic ee, input string nm, input int hold);
        int n0;
        int n1;
        int hi;
        push(rw, ed, ee, nm);
        @(negedge Clk);
        MFA = 1'b1; RW = rw; Size = sz; Signed = sg;
        Address = a; DataIn = d;
        @(posedge Clk);
        n0 = 0;
        n1 = 0;
        for (int i = 1; i <= 8 && n0 == 0; i++) begin
            @(posedge Clk); #1;
            if (MOC1 && n1 == 0) n1 = i;
            if (MOC) n0 = i;
        end
        check({nm, "_lat"}, n0, 2);
        check({nm, "_lat1"}, n1, 1);
        if (hold > 0) begin
            hi = 0;
            DataIn = ~d;
            RW = ~rw;
            for (int i = 0; i < hold; i++) begin
                @(posedge Clk); #1;
                if (MOC) hi++;
            end
            check({nm, "_hold"}, hi, hold);
        end
        @(negedge Clk);
        MFA = 1'b0;
        @(posedge Clk); #1;
        check({nm, "_mocoff"}, {31'h0, MOC}, 32'h0);
    endtask

    task automatic early_drop(input logic [AW-1:0] a, input logic [31:0] ed,
                              input string nm);
        int hi;
        push(RW_READ, ed, 1'b0, nm);
        @(negedge Clk);
        MFA = 1'b1; RW = RW_READ; Size = SZ_WORD; Signed = 1'b0;
        Address = a;
        @(posedge Clk);
        @(negedge Clk);
        MFA = 1'b0;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            if (MOC) hi++;
        end
        check({nm, "_pulse"}, hi, 1);
    endtask

    task automatic chkm(input int i, input logic [7:0] e, input string nm);
        check(nm, {24'h0, dut.Mem[i]}, {24'h0, e});
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        for (int i = 0; i < DEPTH; i++) begin
            dut.Mem[i]  = 8'h00;
            dut1.Mem[i] = 8'h00;
        end
        dut.Mem[0]  = 8'h8C; dut.Mem[1]  = 8'h01;
        dut.Mem[2]  = 8'h00; dut.Mem[3]  = 8'h04;
        dut.Mem[4]  = 8'h11; dut.Mem[6]  = 8'h22;
        dut.Mem[12] = 8'hA1; dut.Mem[13] = 8'hA2;
        dut.Mem[14] = 8'hA3; dut.Mem[15] = 8'hA4;
        for (int i = 0; i < 16; i++) dut1.Mem[i] = dut.Mem[i];

        #2;
        check("rst_moc", {31'h0, MOC}, 32'h0);
        check("rst_err", {31'h0, Err}, 32'h0);
        check("rst_dout", DataOut, 32'h0);
        @(negedge Clk);
        Clear = 1'b1;

        do_req(RW_READ, SZ_WORD, 1'b0, 9'd0, 32'h0, 32'h8C010004, 1'b0, "rd_w0", 0);

        do_req(RW_WRITE, SZ_BYTE, 1'b0, 9'd5, 32'h000000FF, 32'h0, 1'b0, "wr_b5", 0);
        chkm(5, 8'hFF, "mem5");
        chkm(4, 8'h11, "mem4");
        chkm(6, 8'h22, "mem6");
        do_req(RW_READ, SZ_BYTE, 1'b1, 9'd5, 32'h0, 32'hFFFFFFFF, 1'b0, "rd_sb5", 0);
        do_req(RW_READ, SZ_BYTE, 1'b0, 9'd5, 32'h0, 32'h000000FF, 1'b0, "rd_ub5", 0);

        do_req(RW_READ, SZ_HALF, 1'b0, 9'd3, 32'h0, 32'h0, 1'b1, "rd_h3", 0);
        do_req(RW_WRITE, SZ_WORD, 1'b0, 9'd2, 32'h12345678, 32'h0, 1'b1, "wr_w2", 0);
        chkm(2, 8'h00, "mem2");
        chkm(3, 8'h04, "mem3");
        chkm(4, 8'h11, "mem4b");
        chkm(5, 8'hFF, "mem5b");
        do_req(RW_READ, 2'b11, 1'b0, 9'd0, 32'h0, 32'h0, 1'b1, "rd_sz3", 0);

        do_req(RW_WRITE, SZ_WORD, 1'b0, 9'd8, 32'hDEADBEEF, 32'h0, 1'b0, "wr_w8", 0);
        do_req(RW_READ, SZ_HALF, 1'b0, 9'd10, 32'h0, 32'h0000BEEF, 1'b0, "rd_uh10", 0);
        do_req(RW_READ, SZ_HALF, 1'b1, 9'd10, 32'h0, 32'hFFFFBEEF, 1'b0, "rd_sh10", 0);
        do_req(RW_READ, SZ_WORD, 1'b0, 9'd264, 32'h0, 32'hDEADBEEF, 1'b0, "rd_alias", 0);

        @(negedge Clk);
        MFA = 1'b1; RW = RW_WRITE; Size = SZ_WORD; Signed = 1'b0;
        Address = 9'd12; DataIn = 32'h55667788;
        @(posedge Clk); #1;
        Clear = 1'b0;
        #1;
        check("clr_moc", {31'h0, MOC}, 32'h0);
        check("clr_err", {31'h0, Err}, 32'h0);
        check("clr_dout", DataOut, 32'h0);
        check("clr_dout1", DataOut1, 32'h0);
        check("clr_err1", {31'h0, Err1}, 32'h0);
        @(negedge Clk);
        MFA = 1'b0;
        @(negedge Clk);
        Clear = 1'b1;
        @(posedge Clk); #1;
        chkm(12, 8'hA1, "mem12");
        chkm(13, 8'hA2, "mem13");
        chkm(14, 8'hA3, "mem14");
        chkm(15, 8'hA4, "mem15");
        do_req(RW_READ, SZ_WORD, 1'b0, 9'd12, 32'h0, 32'hA1A2A3A4, 1'b0, "rd_w12", 0);

        do_req(RW_WRITE, SZ_WORD, 1'b0, 9'd16, 32'h01020304, 32'h0, 1'b0, "wr_hold", 6);
        chkm(16, 8'h01, "mem16");
        chkm(17, 8'h02, "mem17");
        chkm(18, 8'h03, "mem18");
        chkm(19, 8'h04, "mem19");

        early_drop(9'd16, 32'h01020304, "rd_early");

        repeat (3) @(posedge Clk);
        #1;
        check("sb_left", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_moc_responder.md
Name: mem_moc_responder

Overview:
- Byte-addressed, big-endian memory responder answering CPU datapath load/store requests over the MFA/MOC four-phase handshake.
- Sits on the memory side of the datapath's MAR/MDR bus. Serves instruction fetch and data access.
- Contents are preloadable by bench backdoor (Mem array) and survive reset.
- Parameterised access latency models a slow RAM.

Parameters:
- DEPTH, 512, memory size in bytes; must be a power of two, 4 <= DEPTH <= 2^AW.
- AW, 9, address width in bits.
- LATENCY, 2, cycles from request capture to MOC assertion; minimum 1.

Ports:
- Clk  in  1  system clock; rising edge.
- Clear  in  1  asynchronous, active-low reset.
- MFA  in  1  memory function active; request, held high until MOC seen.
- RW  in  1  1 = read, 0 = write.
- Size  in  2  00 = byte, 01 = halfword, 10 = word; 11 is illegal.
- Signed  in  1  reads only: sign-extend byte/halfword when 1, zero-extend when 0.
- Address  in  AW  byte address.
- DataIn  in  32  write data, right-justified.
- DataOut  out  32  read data, right-justified, extended per Signed.
- MOC  out  1  memory operation complete.
- Err  out  1  misaligned or illegal-size access; valid while MOC = 1.

Behaviour:
- Storage: reg [7:0] Mem[0:DEPTH-1]. Never cleared by reset.
- Byte order: word at A = {Mem[A], Mem[A+1], Mem[A+2], Mem[A+3]}. Halfword at A = {Mem[A], Mem[A+1]}.
- Reset (Clear = 0, async):
  - State -> IDLE; MOC = 0, Err = 0, DataOut = 0.
  - Latency counter = 0.
  - An in-flight write is abandoned and memory is left unchanged.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On a rising edge with MFA = 1, capture RW, Size, Signed, Address and DataIn, then go to BUSY with counter = LATENCY-1.
  - Inputs are ignored after capture.
- BUSY:
  - Decrement the counter each edge.
  - When the counter is 0, go to DONE and perform the access on that edge.
  - Reads: DataOut updated on that edge.
  - Writes: bytes committed on that edge.
  - MOC rises LATENCY cycles after the capture edge.
- DONE:
  - MOC = 1; DataOut and Err held stable.
  - When MFA = 0 is sampled: MOC -> 0, go to IDLE. DataOut keeps its last value.
  - A new request is accepted no earlier than the edge after return to IDLE, so MFA must drop between requests.
- MFA dropping during BUSY: the request completes anyway. DONE then sees MFA = 0 and MOC pulses for exactly one cycle.
- Error cases:
  - Halfword with Address[0] = 1, word with Address[1:0] != 0, or Size = 11 sets Err = 1 with MOC.
  - On error: no write, DataOut = 0.
  - Err clears with MOC.
- Address range: Address is taken modulo DEPTH (upper bits ignored). Aligned accesses never straddle the top.
- Reads return the old contents of the array. Read and write never overlap, since there is one outstanding request.

Decomposition:
- Shared package (mem_pkg):
  - Size codes SZ_BYTE/SZ_HALF/SZ_WORD.
  - RW_READ/RW_WRITE.
  - State encoding ST_IDLE/ST_BUSY/ST_DONE.
- One natural sub-module, mem_lane_align (combinational):
  - Given Size, Signed, Address[1:0] and four read bytes, produce extended DataOut and the Err flag.
  - Given DataIn, produce per-byte write enables.
  - Keeps the FSM file purely sequential.

Test Plan:
- Preload Mem[0..3] = 8C,01,00,04. Word read at address 0 -> MOC high 2 cycles after capture, DataOut = 32'h8C010004, Err = 0. Drop MFA -> MOC low next edge.
- Byte write 8'hFF to address 5, then signed byte read of 5 -> DataOut = 32'hFFFFFFFF. Unsigned read -> 32'h000000FF. Mem[4], Mem[6] unchanged.
- Halfword read at address 3 -> MOC = 1, Err = 1, DataOut = 0. Word write at address 2 -> Err = 1 and Mem[2..5] unchanged.
- Word write 32'hDEADBEEF at 8, then halfword unsigned read at 10 -> 32'h0000BEEF. Word read at 8 + DEPTH (alias) -> 32'hDEADBEEF.
- Assert Clear = 0 mid-BUSY of a word write to 12 -> MOC/Err/DataOut = 0 immediately. Mem[12..15] keep their preload values. The next request after release completes normally.
- MFA held high continuously across two requests -> only one access occurs; MOC stays high until MFA drops. With LATENCY = 1, MOC rises 1 cycle after capture.
